// File: rtl/cache_axi_arbiter_if.sv
// cache_axi_arbiter_if: icache/dcache request ports and bridge read/write channels of the arbiter.
// slave = arbiter view, master = cache/bridge environment view.
interface cache_axi_arbiter_if;
  logic         ic_rd_req;
  logic [2:0]   ic_rd_type;
  logic [31:0]  ic_rd_addr;
  logic         ic_rd_rdy;
  logic         ic_ret_valid;
  logic         ic_ret_last;
  logic [31:0]  ic_ret_data;
  logic         dc_rd_req;
  logic [2:0]   dc_rd_type;
  logic [31:0]  dc_rd_addr;
  logic         dc_rd_rdy;
  logic         dc_ret_valid;
  logic         dc_ret_last;
  logic [31:0]  dc_ret_data;
  logic         dc_wr_req;
  logic [2:0]   dc_wr_type;
  logic [31:0]  dc_wr_addr;
  logic [3:0]   dc_wr_wstrb;
  logic [127:0] dc_wr_data;
  logic         dc_wr_rdy;
  logic         rd_req;
  logic [2:0]   rd_type;
  logic [31:0]  rd_addr;
  logic         rd_rdy;
  logic         ret_valid;
  logic         ret_last;
  logic [31:0]  ret_data;
  logic         wr_req;
  logic [2:0]   wr_type;
  logic [31:0]  wr_addr;
  logic [3:0]   wr_wstrb;
  logic [127:0] wr_data;
  logic         wr_rdy;
  modport slave (
    input  ic_rd_req, ic_rd_type, ic_rd_addr,
    output ic_rd_rdy, ic_ret_valid, ic_ret_last, ic_ret_data,
    input  dc_rd_req, dc_rd_type, dc_rd_addr,
    output dc_rd_rdy, dc_ret_valid, dc_ret_last, dc_ret_data,
    input  dc_wr_req, dc_wr_type, dc_wr_addr, dc_wr_wstrb, dc_wr_data,
    output dc_wr_rdy,
    output rd_req, rd_type, rd_addr,
    input  rd_rdy, ret_valid, ret_last, ret_data,
    output wr_req, wr_type, wr_addr, wr_wstrb, wr_data,
    input  wr_rdy
  );
  modport master (
    output ic_rd_req, ic_rd_type, ic_rd_addr,
    input  ic_rd_rdy, ic_ret_valid, ic_ret_last, ic_ret_data,
    output dc_rd_req, dc_rd_type, dc_rd_addr,
    input  dc_rd_rdy, dc_ret_valid, dc_ret_last, dc_ret_data,
    output dc_wr_req, dc_wr_type, dc_wr_addr, dc_wr_wstrb, dc_wr_data,
    input  dc_wr_rdy,
    input  rd_req, rd_type, rd_addr,
    output rd_rdy, ret_valid, ret_last, ret_data,
    input  wr_req, wr_type, wr_addr, wr_wstrb, wr_data,
    output wr_rdy
  );
endinterface

// File: rtl/cache_axi_arbiter.sv
// cache_axi_arbiter: shares the cache AXI bridge between icache and dcache with a 1-entry write buffer.
// Define ARB_ROUND_ROBIN_EN for round-robin read arbitration; default is fixed dcache > icache.
module cache_axi_arbiter #(
  parameter int LINE_OFS = 4
) (
  input logic                clk,
  input logic                resetn,
  cache_axi_arbiter_if.slave bus
);
  typedef enum logic [1:0] {R_IDLE, R_REQ, R_WAIT} r_state_t;
  typedef enum logic {W_EMPTY, W_FULL} w_state_t;
  r_state_t     r_state_q, r_state_d;
  w_state_t     w_state_q, w_state_d;
  logic         owner_q, owner_d;
  logic [2:0]   buf_type_q, buf_type_d;
  logic [31:0]  buf_addr_q, buf_addr_d;
  logic [3:0]   buf_wstrb_q, buf_wstrb_d;
  logic [127:0] buf_data_q, buf_data_d;
  logic         ic_elig, dc_elig, winner, grant;
`ifdef ARB_ROUND_ROBIN_EN
  logic         rr_ptr_q, rr_ptr_d;
`endif
  // owner 1 = dcache; a requester hitting the buffered write's line waits for the drain
  always_comb begin
    ic_elig = bus.ic_rd_req && !(w_state_q == W_FULL && bus.ic_rd_addr[31:LINE_OFS] == buf_addr_q[31:LINE_OFS]);
    dc_elig = bus.dc_rd_req && !(w_state_q == W_FULL && bus.dc_rd_addr[31:LINE_OFS] == buf_addr_q[31:LINE_OFS]);
    grant = r_state_q == R_IDLE && (ic_elig || dc_elig);
`ifdef ARB_ROUND_ROBIN_EN
    winner = ic_elig && dc_elig ? rr_ptr_q : dc_elig;
    rr_ptr_d = grant ? ~winner : rr_ptr_q;
`else
    winner = dc_elig;
`endif
    owner_d = grant ? winner : owner_q;
    r_state_d = r_state_q;
    if (grant) r_state_d = R_REQ;
    if (r_state_q == R_REQ && bus.rd_rdy) r_state_d = R_WAIT;
    if (r_state_q == R_WAIT && bus.ret_valid && bus.ret_last) r_state_d = R_IDLE;
  end
  always_comb begin
    w_state_d = w_state_q;
    buf_type_d = buf_type_q;
    buf_addr_d = buf_addr_q;
    buf_wstrb_d = buf_wstrb_q;
    buf_data_d = buf_data_q;
    if (w_state_q == W_EMPTY && bus.dc_wr_req) begin
      w_state_d = W_FULL;
      buf_type_d = bus.dc_wr_type;
      buf_addr_d = bus.dc_wr_addr;
      buf_wstrb_d = bus.dc_wr_wstrb;
      buf_data_d = bus.dc_wr_data;
    end
    if (w_state_q == W_FULL && bus.wr_rdy) w_state_d = W_EMPTY;
  end
  always_comb begin
    bus.rd_req = r_state_q == R_REQ;
    bus.rd_type = owner_q ? bus.dc_rd_type : bus.ic_rd_type;
    bus.rd_addr = owner_q ? bus.dc_rd_addr : bus.ic_rd_addr;
    bus.ic_rd_rdy = r_state_q == R_REQ && !owner_q && bus.rd_rdy;
    bus.dc_rd_rdy = r_state_q == R_REQ && owner_q && bus.rd_rdy;
    bus.ic_ret_valid = r_state_q == R_WAIT && !owner_q && bus.ret_valid;
    bus.dc_ret_valid = r_state_q == R_WAIT && owner_q && bus.ret_valid;
    bus.ic_ret_last = r_state_q == R_WAIT && !owner_q && bus.ret_last;
    bus.dc_ret_last = r_state_q == R_WAIT && owner_q && bus.ret_last;
    bus.ic_ret_data = bus.ret_data;
    bus.dc_ret_data = bus.ret_data;
    bus.dc_wr_rdy = w_state_q == W_EMPTY;
    bus.wr_req = w_state_q == W_FULL;
    bus.wr_type = buf_type_q;
    bus.wr_addr = buf_addr_q;
    bus.wr_wstrb = buf_wstrb_q;
    bus.wr_data = buf_data_q;
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state_q <= R_IDLE;
      w_state_q <= W_EMPTY;
      owner_q <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      rr_ptr_q <= 1'b0;
`endif
    end else begin
      r_state_q <= r_state_d;
      w_state_q <= w_state_d;
      owner_q <= owner_d;
`ifdef ARB_ROUND_ROBIN_EN
      rr_ptr_q <= rr_ptr_d;
`endif
    end
  end
  always_ff @(posedge clk) begin
    buf_type_q <= buf_type_d;
    buf_addr_q <= buf_addr_d;
    buf_wstrb_q <= buf_wstrb_d;
    buf_data_q <= buf_data_d;
  end
endmodule
